// File: rtl/sha_sched_pkg.sv
// Shared types and constants for the SHA-2 message schedule: FSM states, sigma rotation table, max rounds.
// Purely declarative; no logic, no latency, no flow control.
package sha_sched_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam int MAX_ROUNDS = 80;

  // Rotate/shift amounts for the two small sigma functions.
  typedef struct packed {
    int s0_r1;
    int s0_r2;
    int s0_sh;
    int s1_r1;
    int s1_r2;
    int s1_sh;
  } sigma_cfg_t;

  localparam sigma_cfg_t SIGMA_256 = '{s0_r1: 7, s0_r2: 18, s0_sh: 3,
                                       s1_r1: 17, s1_r2: 19, s1_sh: 10};
  localparam sigma_cfg_t SIGMA_512 = '{s0_r1: 1, s0_r2: 8, s0_sh: 7,
                                       s1_r1: 19, s1_r2: 61, s1_sh: 6};

  function automatic sigma_cfg_t sigma_cfg(input int word_w);
    return (word_w == 64) ? SIGMA_512 : SIGMA_256;
  endfunction

endpackage

// File: rtl/sha_sigma.sv
// SHA-2 small sigma pair (s0, s1) of one word; WORD_W picks the SHA-256 or SHA-512 amounts.
// Combinational, zero latency, no flow control.
module sha_sigma
  import sha_sched_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] s0,
  output logic [WORD_W-1:0] s1
);

  localparam sigma_cfg_t CFG = sigma_cfg(WORD_W);

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] v, input int n);
    return (v >> n) | (v << (WORD_W - n));
  endfunction

  assign s0 = rotr(x, CFG.s0_r1) ^ rotr(x, CFG.s0_r2) ^ (x >> CFG.s0_sh);
  assign s1 = rotr(x, CFG.s1_r1) ^ rotr(x, CFG.s1_r2) ^ (x >> CFG.s1_sh);

endmodule

// File: rtl/sha_msg_schedule.sv
// SHA-2 message schedule: takes a 16-word block, streams W[0..ROUNDS-1] one word per w handshake (1-cycle load latency).
// w_ready low freezes the word and window; blk_ready only in IDLE. SHA_SCHED_ABORT_EN adds an abort input.
module sha_msg_schedule
  import sha_sched_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 blk_valid,
  output logic                 blk_ready,
  input  logic [16*WORD_W-1:0] blk_data,
`ifdef SHA_SCHED_ABORT_EN
  input  logic                 abort,
`endif
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic [WORD_W-1:0]    w_data,
  output logic [6:0]           w_index,
  output logic                 w_last,
  output logic                 busy
);

  generate
    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_word_w
      $error("sha_msg_schedule: WORD_W must be 32 or 64");
    end
    if (ROUNDS < 16 || ROUNDS > MAX_ROUNDS) begin : g_bad_rounds
      $error("sha_msg_schedule: ROUNDS must be in 16..80");
    end
  endgenerate

  localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);

  state_t            state_q, state_d;
  logic [6:0]        t_q, t_d;
  logic [WORD_W-1:0] win_q [16];
  logic [WORD_W-1:0] win_d [16];
  logic [WORD_W-1:0] s0_win1, s1_win14, s1_unused_win1, s0_unused_win14;
  logic [WORD_W-1:0] w_next;
  logic              streaming;

  sha_sigma #(.WORD_W(WORD_W)) u_sigma_win1 (
    .x  (win_q[1]),
    .s0 (s0_win1),
    .s1 (s1_unused_win1)
  );

  sha_sigma #(.WORD_W(WORD_W)) u_sigma_win14 (
    .x  (win_q[14]),
    .s0 (s0_unused_win14),
    .s1 (s1_win14)
  );

  // W[t+16] from the current window, modulo 2^WORD_W.
  assign w_next = s1_win14 + win_q[9] + s0_win1 + win_q[0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      t_q     <= '0;
      win_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      win_q   <= win_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    win_d   = win_q;
    case (state_q)
      IDLE: begin
        if (blk_valid) begin
          for (int i = 0; i < 16; i++) begin
            win_d[i] = blk_data[WORD_W*(15-i) +: WORD_W];
          end
          t_d     = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
`ifdef SHA_SCHED_ABORT_EN
        if (abort) begin
          state_d = IDLE;
        end else
`endif
        if (w_ready) begin
          for (int i = 0; i < 15; i++) begin
            win_d[i] = win_q[i+1];
          end
          win_d[15] = w_next;
          t_d       = t_q + 7'd1;
          if (t_q == LAST_T) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are gated by reset so they read as idle for the whole reset pulse.
  assign streaming = (state_q == STREAM) && !reset;
  assign blk_ready = (state_q == IDLE) && !reset;
  assign w_valid   = streaming;
  assign busy      = streaming;
  assign w_data    = reset ? '0 : win_q[0];
  assign w_index   = reset ? '0 : t_q;
  assign w_last    = streaming && (t_q == LAST_T);

endmodule
